// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multi-cycle instruction fetch unit with PC sequencing and misaligned-target trap
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        Jump,
    input  logic        Jr,
    input  logic        Branch,
    input  logic        branch_cond,
    input  logic [31:0] rs_data,
    input  logic        exec_stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;

    // Low for the first cycle out of reset so the first request starts one edge later
    logic        fetch_en;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        addr_err_q;

    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic [31:0] jump_tgt;
    logic        target_misaligned;
    logic        fetch_accept;
    logic        exec_advance;

    assign pc_plus4          = pc_q + 32'd4;
    assign branch_off        = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign jump_tgt          = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    assign target_misaligned = (next_pc[1:0] != 2'b00);
    assign fetch_accept      = (state == FETCH) && fetch_en && im_ready;
    assign exec_advance      = (state == EXEC) && !exec_stall;

    // Next PC selection: register jump beats absolute jump beats taken branch beats sequential
    always_comb begin
        next_pc = pc_plus4;
        if (Jr) begin
            next_pc = rs_data;
        end else if (Jump) begin
            next_pc = jump_tgt;
        end else if (Branch && branch_cond) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; ERR is terminal until reset
    always_comb begin
        state_n = state;
        case (state)
            FETCH: begin
                if (fetch_en && im_ready) begin
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (!exec_stall) begin
                    state_n = target_misaligned ? ERR : FETCH;
                end
            end
            ERR: begin
                state_n = ERR;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // Output decode from state
    always_comb begin
        im_req      = 1'b0;
        instr_valid = 1'b0;
        case (state)
            FETCH:   im_req      = fetch_en;
            EXEC:    instr_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers: instruction capture, PC update and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_en   <= 1'b0;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            addr_err_q <= 1'b0;
        end else begin
            fetch_en <= 1'b1;
            if (fetch_accept) begin
                instr_q <= im_rdata;
            end
            if (exec_advance) begin
                if (target_misaligned) begin
                    addr_err_q <= 1'b1;
                end else begin
                    pc_q <= next_pc;
                end
            end
        end
    end

    assign im_addr  = pc_q;
    assign pc       = pc_q;
    assign instr    = instr_q;
    assign opcode   = instr_q[31:26];
    assign funct    = instr_q[5:0];
    assign addr_err = addr_err_q;

endmodule
